apb2axi: RTL

APB-slave to AXI4-master bridge: lets an APB peripheral master (debug module, boot controller) reach the AXI interconnect. Each APB transfer becomes exactly one single-beat AXI4 transaction, with one outstanding at a time. The APB access phase is stretched with PREADY until the AXI response returns. It is the counterpart of the AXI-to-APB bridge used on the peripheral side of the SoC.

---
 rtl/apb2axi_if.sv | 84 ++++++++
 rtl/apb2axi.sv | 139 +++++++++++++
 2 files changed

// File: rtl/apb2axi_if.sv
// Bus bundles for the APB-to-AXI4 bridge: an APB3/4 port and a single-beat AXI4 port.
// Signal names keep the bus-standard spelling so waveforms line up with the interconnect.
interface apb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W/8-1:0] PSTRB;
    logic [2:0]          PPROT;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                    output PRDATA, PREADY, PSLVERR);
endinterface

interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 16,
    parameter int USER_W = 10
);
    logic                AWVALID_o, AWREADY_i;
    logic [ADDR_W-1:0]   AWADDR_o;
    logic [2:0]          AWPROT_o;
    logic [ID_W-1:0]     AWID_o;
    logic [USER_W-1:0]   AWUSER_o;
    logic [7:0]          AWLEN_o;
    logic [2:0]          AWSIZE_o;
    logic [1:0]          AWBURST_o;
    logic                AWLOCK_o;
    logic [3:0]          AWCACHE_o, AWREGION_o, AWQOS_o;
    logic                WVALID_o, WREADY_i;
    logic [DATA_W-1:0]   WDATA_o;
    logic [DATA_W/8-1:0] WSTRB_o;
    logic                WLAST_o;
    logic [USER_W-1:0]   WUSER_o;
    logic                BVALID_i, BREADY_o;
    logic [1:0]          BRESP_i;
    logic [ID_W-1:0]     BID_i;
    logic [USER_W-1:0]   BUSER_i;
    logic                ARVALID_o, ARREADY_i;
    logic [ADDR_W-1:0]   ARADDR_o;
    logic [2:0]          ARPROT_o;
    logic [ID_W-1:0]     ARID_o;
    logic [USER_W-1:0]   ARUSER_o;
    logic [7:0]          ARLEN_o;
    logic [2:0]          ARSIZE_o;
    logic [1:0]          ARBURST_o;
    logic                ARLOCK_o;
    logic [3:0]          ARCACHE_o, ARREGION_o, ARQOS_o;
    logic                RVALID_i, RREADY_o;
    logic [DATA_W-1:0]   RDATA_i;
    logic [1:0]          RRESP_i;
    logic                RLAST_i;
    logic [ID_W-1:0]     RID_i;
    logic [USER_W-1:0]   RUSER_i;

    modport master (
        output AWVALID_o, AWADDR_o, AWPROT_o, AWID_o, AWUSER_o, AWLEN_o, AWSIZE_o,
               AWBURST_o, AWLOCK_o, AWCACHE_o, AWREGION_o, AWQOS_o,
               WVALID_o, WDATA_o, WSTRB_o, WLAST_o, WUSER_o, BREADY_o,
               ARVALID_o, ARADDR_o, ARPROT_o, ARID_o, ARUSER_o, ARLEN_o, ARSIZE_o,
               ARBURST_o, ARLOCK_o, ARCACHE_o, ARREGION_o, ARQOS_o, RREADY_o,
        input  AWREADY_i, WREADY_i, BVALID_i, BRESP_i, BID_i, BUSER_i,
               ARREADY_i, RVALID_i, RDATA_i, RRESP_i, RLAST_i, RID_i, RUSER_i
    );
    modport slave (
        input  AWVALID_o, AWADDR_o, AWPROT_o, AWID_o, AWUSER_o, AWLEN_o, AWSIZE_o,
               AWBURST_o, AWLOCK_o, AWCACHE_o, AWREGION_o, AWQOS_o,
               WVALID_o, WDATA_o, WSTRB_o, WLAST_o, WUSER_o, BREADY_o,
               ARVALID_o, ARADDR_o, ARPROT_o, ARID_o, ARUSER_o, ARLEN_o, ARSIZE_o,
               ARBURST_o, ARLOCK_o, ARCACHE_o, ARREGION_o, ARQOS_o, RREADY_o,
        output AWREADY_i, WREADY_i, BVALID_i, BRESP_i, BID_i, BUSER_i,
               ARREADY_i, RVALID_i, RDATA_i, RRESP_i, RLAST_i, RID_i, RUSER_i
    );
endinterface

// File: rtl/apb2axi.sv
// APB slave to AXI4 master bridge: each APB transfer becomes one single-beat AXI4
// transaction; PREADY is held low until the AXI response has been registered.
module apb2axi #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int APB_ADDR_WIDTH     = 32,
    parameter int AXI_ID             = 0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    apb_if.slave        apb,
    axi_if.master       axi,
    output logic [2:0]  state_dbg
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam int STRB_W = AXI4_DATA_WIDTH / 8;

    logic [2:0]                    state;
    logic                          aw_done, w_done;
    logic                          aw_hs, w_hs;
    logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
    logic [AXI4_DATA_WIDTH-1:0]    wdata_q;
    logic [STRB_W-1:0]             strb_q;
    logic [2:0]                    prot_q;
    logic                          unused_inputs;

    assign state_dbg = state;

    // Every AXI channel follows valid/ready: a transfer happens on a rising edge where
    // both are high; VALID is a pure decode of registered state, so once raised it holds
    // until its own handshake and never depends combinationally on any READY.
    assign aw_hs = axi.AWVALID_o & axi.AWREADY_i;
    assign w_hs  = axi.WVALID_o & axi.WREADY_i;

    assign axi.AWVALID_o = (state == WR_REQ) && !aw_done;
    assign axi.WVALID_o  = (state == WR_REQ) && !w_done;
    assign axi.BREADY_o  = (state == WR_RESP);
    assign axi.ARVALID_o = (state == RD_REQ);
    assign axi.RREADY_o  = (state == RD_RESP);

    assign axi.AWADDR_o   = addr_q;
    assign axi.AWPROT_o   = prot_q;
    assign axi.AWID_o     = AXI4_ID_WIDTH'(AXI_ID);
    assign axi.AWUSER_o   = '0;
    assign axi.AWLEN_o    = 8'd0;
    assign axi.AWSIZE_o   = 3'($clog2(STRB_W));
    assign axi.AWBURST_o  = 2'b01;
    assign axi.AWLOCK_o   = 1'b0;
    assign axi.AWCACHE_o  = 4'd0;
    assign axi.AWREGION_o = 4'd0;
    assign axi.AWQOS_o    = 4'd0;

    assign axi.WDATA_o = wdata_q;
    assign axi.WSTRB_o = strb_q;
    assign axi.WLAST_o = 1'b1;
    assign axi.WUSER_o = '0;

    assign axi.ARADDR_o   = addr_q;
    assign axi.ARPROT_o   = prot_q;
    assign axi.ARID_o     = AXI4_ID_WIDTH'(AXI_ID);
    assign axi.ARUSER_o   = '0;
    assign axi.ARLEN_o    = 8'd0;
    assign axi.ARSIZE_o   = 3'($clog2(STRB_W));
    assign axi.ARBURST_o  = 2'b01;
    assign axi.ARLOCK_o   = 1'b0;
    assign axi.ARCACHE_o  = 4'd0;
    assign axi.ARREGION_o = 4'd0;
    assign axi.ARQOS_o    = 4'd0;

    // IDs, user bits, RLAST and the low response bit carry no meaning for a single-beat bridge.
    assign unused_inputs = ^{axi.BID_i, axi.BUSER_i, axi.RID_i, axi.RUSER_i, axi.RLAST_i,
                             axi.BRESP_i[0], axi.RRESP_i[0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            prot_q      <= 3'd0;
            apb.PRDATA  <= '0;
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
        end else begin
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a setup phase starts a transfer; PSEL with PENABLE here is ignored.
                    if (apb.PSEL && !apb.PENABLE) begin
                        addr_q  <= AXI4_ADDRESS_WIDTH'(apb.PADDR);
                        wdata_q <= apb.PWDATA;
                        strb_q  <= apb.PSTRB;
                        prot_q  <= apb.PPROT;
                        state   <= apb.PWRITE ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.BVALID_i) begin
                        apb.PREADY  <= 1'b1;
                        apb.PSLVERR <= axi.BRESP_i[1];
                        state       <= DONE;
                    end
                end
                RD_REQ: begin
                    if (axi.ARREADY_i) state <= RD_RESP;
                end
                RD_RESP: begin
                    if (axi.RVALID_i) begin
                        apb.PRDATA  <= axi.RDATA_i;
                        apb.PREADY  <= 1'b1;
                        apb.PSLVERR <= axi.RRESP_i[1];
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
